// File: rtl/trace_eject_pkg.sv
// Shared state encodings, error codes and slot geometry for the trace ejection unit.
// Also provides the flit field-position macros used by the local port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef DATA_MSB
`define DATA_MSB 63
`endif
`ifndef NUM_MSB
`define NUM_MSB 20
`endif
`ifndef NUM_LSB
`define NUM_LSB 16
`endif
`ifndef IDX_MSB
`define IDX_MSB 25
`endif
`ifndef IDX_LSB
`define IDX_LSB 21
`endif

package trace_eject_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BODY,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } te_state_t;

  localparam logic [1:0] TE_OK     = 2'b00;
  localparam logic [1:0] TE_BADNUM = 2'b01;
  localparam logic [1:0] TE_IDX    = 2'b10;
  localparam logic [1:0] TE_TRACE  = 2'b11;

  localparam int RID_WIDTH    = 4;
  localparam int LO_SLOT_BASE = 1;
  localparam int HI_SLOT_BASE = 13;
  localparam int LO_SLOTS     = 12;
  localparam int HI_SLOTS     = 4;

  // Header sanity: hop count must be 1..max_hops, and the stamp index must have reached it.
  function automatic logic [1:0] hdr_check(input logic [4:0] num, input logic [4:0] idx,
                                           input int max_hops);
    logic [1:0] res;
    res = TE_OK;
    if (num == 5'd0 || int'(num) > max_hops) res = TE_BADNUM;
    else if (idx != num)                      res = TE_IDX;
    return res;
  endfunction

endpackage

// File: rtl/trace_eject_if.sv
// Local-port ejection bus: flit input channel, hop record stream and packet status.
// hop_port exists only when TRACE_PORT_EN is defined.
interface trace_eject_if;
  import trace_eject_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [`DATA_WIDTH-1:0] in_data;
  logic                   in_head;
  logic                   in_tail;
  logic                   hop_valid;
  logic                   hop_ready;
  logic [4:0]             hop_idx;
  logic [RID_WIDTH-1:0]   hop_rid;
  logic                   hop_last;
`ifdef TRACE_PORT_EN
  logic [1:0]             hop_port;
`endif
  logic                   pkt_done;
  logic                   pkt_err;
  logic [1:0]             err_code;

  modport master (
`ifdef TRACE_PORT_EN
    input  hop_port,
`endif
    output in_valid, in_data, in_head, in_tail, hop_ready,
    input  in_ready, hop_valid, hop_idx, hop_rid, hop_last, pkt_done, pkt_err, err_code
  );

  modport slave (
`ifdef TRACE_PORT_EN
    output hop_port,
`endif
    input  in_valid, in_data, in_head, in_tail, hop_ready,
    output in_ready, hop_valid, hop_idx, hop_rid, hop_last, pkt_done, pkt_err, err_code
  );

endinterface

// File: rtl/trace_eject_slot_mux.sv
// trace_slot_mux: picks the recorded router ID (and path port) for a 1-based hop index.
// Purely combinational; index 0 or beyond the last slot yields zero.
module trace_slot_mux
  import trace_eject_pkg::*;
(
  input  logic [4:0]                    sel,
  input  logic [LO_SLOTS*RID_WIDTH-1:0] lo_slots,
  input  logic [HI_SLOTS*RID_WIDTH-1:0] hi_slots,
`ifdef TRACE_PORT_EN
  input  logic [31:0]                   path,
  output logic [1:0]                    port,
`endif
  output logic [RID_WIDTH-1:0]          rid
);

  always_comb begin
    rid = '0;
    for (int k = 0; k < LO_SLOTS; k++)
      if (sel == 5'(LO_SLOT_BASE + k)) rid = lo_slots[k*RID_WIDTH +: RID_WIDTH];
    for (int k = 0; k < HI_SLOTS; k++)
      if (sel == 5'(HI_SLOT_BASE + k)) rid = hi_slots[k*RID_WIDTH +: RID_WIDTH];
  end

`ifdef TRACE_PORT_EN
  // Hop 1 took the two most significant path bits, each later hop the next pair down.
  always_comb begin
    port = '0;
    for (int k = 0; k < LO_SLOTS + HI_SLOTS; k++)
      if (sel == 5'(k + 1)) port = path[31-2*k -: 2];
  end
`endif

endmodule

// File: rtl/trace_eject.sv
// Ejection unit: unpacks the hop-stamped router trace of each packet and streams one record per cycle.
// Latency: first hop record the cycle after the tail is accepted; in_ready is low while emitting or reporting.
// Optional TRACE_PORT_EN adds hop_port, taken from the latched header path field.
module trace_eject
  import trace_eject_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int MAX_HOPS = 16
) (
  input logic         clk,
  input logic         reset,
  trace_eject_if.slave te
);

  te_state_t                     state_q, state_d;
  logic                          live_q;
  logic [4:0]                    num_q;
  logic [4:0]                    hop_idx_q, hop_idx_d;
  logic [1:0]                    err_q, err_d;
  logic [LO_SLOTS*RID_WIDTH-1:0] lo_q;
  logic [HI_SLOTS*RID_WIDTH-1:0] hi_q;
  logic                          load_hdr, load_body;
  logic                          xfer, head_abort, hop_last;
  logic [RID_WIDTH-1:0]          sel_rid;
  logic [4:0]                    in_num, in_idx;
  logic                          unused_data;

  assign in_num      = te.in_data[`NUM_MSB:`NUM_LSB];
  assign in_idx      = te.in_data[`IDX_MSB:`IDX_LSB];
  assign unused_data = ^te.in_data;

  // A head arriving mid-packet is refused so it can start the next packet after the abort.
  assign head_abort  = te.in_valid && te.in_head && (state_q == ST_BODY || state_q == ST_DRAIN);
  assign te.in_ready = live_q && ((state_q == ST_IDLE) ||
                       ((state_q == ST_BODY || state_q == ST_DRAIN) && !head_abort));
  assign xfer        = te.in_valid && te.in_ready;
  assign hop_last    = (state_q == ST_EMIT) && (hop_idx_q == num_q);

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    hop_idx_d = hop_idx_q;
    load_hdr  = 1'b0;
    load_body = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer && te.in_head) begin
          load_hdr  = 1'b1;
          hop_idx_d = '0;
          err_d     = te.in_tail ? TE_TRACE : hdr_check(in_num, in_idx, MAX_HOPS);
          state_d   = te.in_tail ? ST_DONE : ST_BODY;
        end
      end
      ST_BODY, ST_DRAIN: begin
        if (head_abort) begin
          err_d   = TE_TRACE;
          state_d = ST_DONE;
        end else if (xfer) begin
          load_body = (state_q == ST_BODY);
          if (!te.in_tail) begin
            state_d = ST_DRAIN;
          end else if (err_q == TE_OK) begin
            state_d   = ST_EMIT;
            hop_idx_d = 5'd1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_EMIT: begin
        if (te.hop_ready) begin
          if (hop_last) begin
            state_d   = ST_DONE;
            hop_idx_d = '0;
            if (sel_rid != RID_WIDTH'(ROUTERID)) err_d = TE_TRACE;
          end else begin
            hop_idx_d = hop_idx_q + 5'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      live_q    <= 1'b0;
      num_q     <= '0;
      err_q     <= TE_OK;
      hop_idx_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      live_q    <= 1'b1;
      state_q   <= state_d;
      err_q     <= err_d;
      hop_idx_q <= hop_idx_d;
      if (load_hdr) begin
        num_q <= in_num;
        hi_q  <= te.in_data[HI_SLOTS*RID_WIDTH-1:0];
      end
      if (load_body) lo_q <= te.in_data[LO_SLOTS*RID_WIDTH-1:0];
    end
  end

`ifdef TRACE_PORT_EN
  logic [31:0] path_q;
  logic [1:0]  sel_port;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        path_q <= '0;
    else if (load_hdr) path_q <= te.in_data[`DATA_MSB -: 32];
  end

  trace_slot_mux u_mux (
    .sel     (hop_idx_q),
    .lo_slots(lo_q),
    .hi_slots(hi_q),
    .path    (path_q),
    .port    (sel_port),
    .rid     (sel_rid)
  );

  assign te.hop_port = sel_port;
`else
  trace_slot_mux u_mux (
    .sel     (hop_idx_q),
    .lo_slots(lo_q),
    .hi_slots(hi_q),
    .rid     (sel_rid)
  );
`endif

  assign te.hop_valid = (state_q == ST_EMIT);
  assign te.hop_idx   = hop_idx_q;
  assign te.hop_rid   = sel_rid;
  assign te.hop_last  = hop_last;
  assign te.pkt_done  = (state_q == ST_DONE);
  assign te.pkt_err   = (state_q == ST_DONE) && (err_q != TE_OK);
  assign te.err_code  = (state_q == ST_DONE) ? err_q : TE_OK;

endmodule

// File: tb/tb_trace_eject.sv
// Directed bench for trace_eject: clean, long, stalled, malformed, aborted and reset-interrupted packets.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef DATA_MSB
`define DATA_MSB 63
`endif
`ifndef NUM_MSB
`define NUM_MSB 20
`endif
`ifndef NUM_LSB
`define NUM_LSB 16
`endif
`ifndef IDX_MSB
`define IDX_MSB 25
`endif
`ifndef IDX_LSB
`define IDX_LSB 21
`endif

module tb_trace_eject;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  trace_eject_if bus();

  trace_eject #(.ROUTERID(10), .MAX_HOPS(16)) dut (
    .clk  (clk),
    .reset(reset),
    .te   (bus.slave)
  );

  always #5 clk = ~clk;

  // Record monitor, sampled on the falling edge.
  logic [4:0] rec_idx  [0:255];
  logic [3:0] rec_rid  [0:255];
  logic       rec_last [0:255];
  logic [1:0] rec_port [0:255];
  logic [1:0] done_err [0:255];
  logic       done_perr[0:255];
  int nrec = 0, ndone = 0, ready_viol = 0, stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [4:0] prev_idx = '0;
  logic [3:0] prev_rid = '0;

  always @(negedge clk) begin
    if (reset && bus.hop_valid && bus.hop_ready && nrec < 256) begin
      rec_idx[nrec]  = bus.hop_idx;
      rec_rid[nrec]  = bus.hop_rid;
      rec_last[nrec] = bus.hop_last;
`ifdef TRACE_PORT_EN
      rec_port[nrec] = bus.hop_port;
`else
      rec_port[nrec] = 2'b00;
`endif
      nrec++;
    end
    if (bus.hop_valid && bus.in_ready) ready_viol++;
    if (reset && prev_stall && (!bus.hop_valid || bus.hop_idx !== prev_idx || bus.hop_rid !== prev_rid))
      stall_viol++;
    prev_stall = reset && bus.hop_valid && !bus.hop_ready;
    prev_idx   = bus.hop_idx;
    prev_rid   = bus.hop_rid;
    if (bus.pkt_done && ndone < 256) begin
      done_err[ndone]  = bus.err_code;
      done_perr[ndone] = bus.pkt_err;
      ndone++;
    end
  end

  function automatic logic [`DATA_WIDTH-1:0] mk_head(input logic [4:0] num, input logic [4:0] idx,
                                                     input logic [15:0] hi, input logic [31:0] path);
    logic [`DATA_WIDTH-1:0] d;
    d = '0;
    d[15:0] = hi;
    d[`NUM_MSB:`NUM_LSB] = num;
    d[`IDX_MSB:`IDX_LSB] = idx;
    d[`DATA_MSB -: 32] = path;
    return d;
  endfunction

  // Called and returns at one time unit after a rising edge.
  task automatic send_flit(input logic [`DATA_WIDTH-1:0] d, input logic h, input logic t);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_head = h; bus.in_tail = t;
    #1;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b want=1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_head = 1'b0; bus.in_tail = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (ndone < target && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (ndone < target) begin
      errors++; $display("FAIL done_timeout got=%0d want=%0d", ndone, target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", bus.in_ready); end
    checks++; if (bus.hop_valid !== 1'b0) begin errors++; $display("FAIL rst_hop_valid got=%b want=0", bus.hop_valid); end
    checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL rst_pkt_done got=%b want=0", bus.pkt_done); end
    checks++; if (bus.pkt_err !== 1'b0) begin errors++; $display("FAIL rst_pkt_err got=%b want=0", bus.pkt_err); end
    checks++; if (bus.err_code !== 2'b00) begin errors++; $display("FAIL rst_err_code got=%b want=00", bus.err_code); end
    checks++; if (bus.hop_idx !== 5'd0) begin errors++; $display("FAIL rst_hop_idx got=%0d want=0", bus.hop_idx); end
    checks++; if (bus.hop_rid !== 4'd0) begin errors++; $display("FAIL rst_hop_rid got=%0d want=0", bus.hop_rid); end
    checks++; if (bus.hop_last !== 1'b0) begin errors++; $display("FAIL rst_hop_last got=%b want=0", bus.hop_last); end
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    int b = nrec;
    int dn = ndone;
    logic [3:0] exp_rid [4];
    exp_rid = '{4'd3, 4'd1, 4'd5, 4'hA};
    bus.hop_ready = 1'b1;
    send_flit(mk_head(5'd4, 5'd4, 16'h0000, 32'hE400_0000), 1'b1, 1'b0);
    send_flit({16'h0, 48'h0000_0000_A513}, 1'b0, 1'b1);
    checks++; if (bus.hop_valid !== 1'b1) begin errors++; $display("FAIL clean_latency_valid got=%b want=1", bus.hop_valid); end
    checks++; if (bus.hop_idx !== 5'd1) begin errors++; $display("FAIL clean_first_idx got=%0d want=1", bus.hop_idx); end
    checks++; if (bus.hop_rid !== 4'd3) begin errors++; $display("FAIL clean_first_rid got=%0d want=3", bus.hop_rid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clean_emit_in_ready got=%b want=0", bus.in_ready); end
    wait_done(dn + 1);
    checks++; if (nrec - b !== 4) begin errors++; $display("FAIL clean_count got=%0d want=4", nrec - b); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rec_idx[b+i] !== 5'(i + 1) || rec_rid[b+i] !== exp_rid[i] || rec_last[b+i] !== (i == 3)) begin
        errors++;
        $display("FAIL clean_rec%0d got idx=%0d rid=%h last=%b want idx=%0d rid=%h last=%b",
                 i, rec_idx[b+i], rec_rid[b+i], rec_last[b+i], i + 1, exp_rid[i], (i == 3));
      end
`ifdef TRACE_PORT_EN
      checks++;
      if (rec_port[b+i] !== 2'(3 - i)) begin
        errors++; $display("FAIL clean_port%0d got=%0d want=%0d", i, rec_port[b+i], 3 - i);
      end
`endif
    end
    checks++; if (done_err[dn] !== 2'b00 || done_perr[dn] !== 1'b0) begin
      errors++; $display("FAIL clean_status got err=%b perr=%b want err=00 perr=0", done_err[dn], done_perr[dn]);
    end
  endtask

  task automatic test_long_path();
    int b = nrec;
    int dn = ndone;
    logic [3:0] want;
    bus.hop_ready = 1'b1;
    send_flit(mk_head(5'd14, 5'd14, 16'h00A9, 32'h0), 1'b1, 1'b0);
    send_flit({16'h0, 48'hCBA9_8765_4321}, 1'b0, 1'b0);
    send_flit({`DATA_WIDTH{1'b1}}, 1'b0, 1'b1);
    wait_done(dn + 1);
    checks++; if (nrec - b !== 14) begin errors++; $display("FAIL long_count got=%0d want=14", nrec - b); end
    for (int i = 0; i < 14; i++) begin
      want = (i < 12) ? 4'(i + 1) : ((i == 12) ? 4'd9 : 4'hA);
      checks++;
      if (rec_idx[b+i] !== 5'(i + 1) || rec_rid[b+i] !== want || rec_last[b+i] !== (i == 13)) begin
        errors++;
        $display("FAIL long_rec%0d got idx=%0d rid=%h last=%b want idx=%0d rid=%h last=%b",
                 i, rec_idx[b+i], rec_rid[b+i], rec_last[b+i], i + 1, want, (i == 13));
      end
    end
    checks++; if (done_err[dn] !== 2'b00) begin errors++; $display("FAIL long_err got=%b want=00", done_err[dn]); end
  endtask

  task automatic test_backpressure();
    int b = nrec;
    int dn = ndone;
    int sv = stall_viol;
    int rv = ready_viol;
    logic [7:0] pat;
    logic [3:0] exp_rid [4];
    exp_rid = '{4'd6, 4'd2, 4'd8, 4'hA};
    pat = 8'b1110_1001;
    bus.hop_ready = 1'b1;
    send_flit(mk_head(5'd4, 5'd4, 16'h0000, 32'h0), 1'b1, 1'b0);
    send_flit({16'h0, 48'h0000_0000_A826}, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      bus.hop_ready = pat[c];
      if (c == 2) begin
        #1;
        checks++; if (bus.hop_idx !== 5'd2 || bus.hop_rid !== 4'd2 || bus.hop_valid !== 1'b1) begin
          errors++; $display("FAIL bp_hold got idx=%0d rid=%0d vld=%b want idx=2 rid=2 vld=1",
                             bus.hop_idx, bus.hop_rid, bus.hop_valid);
        end
      end
      @(posedge clk); #1;
    end
    bus.hop_ready = 1'b1;
    wait_done(dn + 1);
    checks++; if (nrec - b !== 4) begin errors++; $display("FAIL bp_count got=%0d want=4", nrec - b); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rec_idx[b+i] !== 5'(i + 1) || rec_rid[b+i] !== exp_rid[i]) begin
        errors++; $display("FAIL bp_rec%0d got idx=%0d rid=%h want idx=%0d rid=%h",
                           i, rec_idx[b+i], rec_rid[b+i], i + 1, exp_rid[i]);
      end
    end
    checks++; if (stall_viol - sv !== 0) begin errors++; $display("FAIL bp_stable got=%0d want=0", stall_viol - sv); end
    checks++; if (ready_viol - rv !== 0) begin errors++; $display("FAIL bp_in_ready got=%0d want=0", ready_viol - rv); end
  endtask

  task automatic test_bad_header();
    int b = nrec;
    int dn = ndone;
    send_flit(mk_head(5'd0, 5'd0, 16'h0, 32'h0), 1'b1, 1'b0);
    send_flit({16'h0, 48'h0000_0000_A123}, 1'b0, 1'b1);
    wait_done(dn + 1);
    send_flit(mk_head(5'd5, 5'd3, 16'h0, 32'h0), 1'b1, 1'b0);
    send_flit({16'h0, 48'h0000_000A_4321}, 1'b0, 1'b1);
    wait_done(dn + 2);
    send_flit(mk_head(5'd17, 5'd17, 16'h0, 32'h0), 1'b1, 1'b0);
    send_flit({16'h0, 48'h0}, 1'b0, 1'b1);
    wait_done(dn + 3);
    checks++; if (done_err[dn] !== 2'b01 || done_perr[dn] !== 1'b1) begin
      errors++; $display("FAIL bad_num0 got err=%b perr=%b want err=01 perr=1", done_err[dn], done_perr[dn]);
    end
    checks++; if (done_err[dn+1] !== 2'b10 || done_perr[dn+1] !== 1'b1) begin
      errors++; $display("FAIL bad_idx got err=%b perr=%b want err=10 perr=1", done_err[dn+1], done_perr[dn+1]);
    end
    checks++; if (done_err[dn+2] !== 2'b01) begin
      errors++; $display("FAIL bad_num17 got err=%b want err=01", done_err[dn+2]);
    end
    checks++; if (nrec - b !== 0) begin errors++; $display("FAIL bad_records got=%0d want=0", nrec - b); end
  endtask

  task automatic test_missing_body();
    int b = nrec;
    int dn = ndone;
    logic [3:0] exp_rid [3];
    exp_rid = '{4'd4, 4'd5, 4'hA};
    bus.hop_ready = 1'b1;
    send_flit(mk_head(5'd2, 5'd2, 16'h0, 32'h0), 1'b1, 1'b1);
    wait_done(dn + 1);
    checks++; if (done_err[dn] !== 2'b11 || done_perr[dn] !== 1'b1 || nrec - b !== 0) begin
      errors++; $display("FAIL nobody got err=%b perr=%b recs=%0d want err=11 perr=1 recs=0",
                         done_err[dn], done_perr[dn], nrec - b);
    end
    send_flit(mk_head(5'd3, 5'd3, 16'h0, 32'h0), 1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = mk_head(5'd3, 5'd3, 16'h0, 32'h0);
    bus.in_head = 1'b1; bus.in_tail = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got=%b want=0", bus.in_ready); end
    send_flit(mk_head(5'd3, 5'd3, 16'h0, 32'h0), 1'b1, 1'b0);
    send_flit({16'h0, 48'h0000_0000_0A54}, 1'b0, 1'b1);
    wait_done(dn + 3);
    checks++; if (done_err[dn+1] !== 2'b11) begin errors++; $display("FAIL abort_err got=%b want=11", done_err[dn+1]); end
    checks++; if (done_err[dn+2] !== 2'b00 || done_perr[dn+2] !== 1'b0) begin
      errors++; $display("FAIL abort_next got err=%b perr=%b want err=00 perr=0", done_err[dn+2], done_perr[dn+2]);
    end
    checks++; if (nrec - b !== 3) begin errors++; $display("FAIL abort_count got=%0d want=3", nrec - b); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rec_rid[b+i] !== exp_rid[i] || rec_last[b+i] !== (i == 2)) begin
        errors++; $display("FAIL abort_rec%0d got rid=%h last=%b want rid=%h last=%b",
                           i, rec_rid[b+i], rec_last[b+i], exp_rid[i], (i == 2));
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    int b;
    int dn = ndone;
    bus.hop_ready = 1'b0;
    send_flit(mk_head(5'd4, 5'd4, 16'h0, 32'h0), 1'b1, 1'b0);
    send_flit({16'h0, 48'h0000_0000_A513}, 1'b0, 1'b1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checks++; if (bus.hop_valid !== 1'b0 || bus.hop_idx !== 5'd0 || bus.hop_rid !== 4'd0 || bus.hop_last !== 1'b0) begin
      errors++; $display("FAIL mid_rst_hop got vld=%b idx=%0d rid=%0d last=%b want all 0",
                         bus.hop_valid, bus.hop_idx, bus.hop_rid, bus.hop_last);
    end
    checks++; if (bus.in_ready !== 1'b0 || bus.pkt_done !== 1'b0 || bus.err_code !== 2'b00) begin
      errors++; $display("FAIL mid_rst_status got rdy=%b done=%b err=%b want 0 0 00",
                         bus.in_ready, bus.pkt_done, bus.err_code);
    end
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ndone !== dn) begin errors++; $display("FAIL mid_rst_no_pulse got=%0d want=%0d", ndone, dn); end
    b = nrec;
    bus.hop_ready = 1'b1;
    send_flit(mk_head(5'd4, 5'd4, 16'h0, 32'h0), 1'b1, 1'b0);
    send_flit({16'h0, 48'h0000_0000_A513}, 1'b0, 1'b1);
    wait_done(dn + 1);
    checks++; if (nrec - b !== 4 || done_err[dn] !== 2'b00) begin
      errors++; $display("FAIL mid_rst_next got recs=%0d err=%b want recs=4 err=00", nrec - b, done_err[dn]);
    end
    checks++; if (rec_rid[b] !== 4'd3 || rec_rid[b+3] !== 4'hA) begin
      errors++; $display("FAIL mid_rst_rids got first=%h last=%h want 3 a", rec_rid[b], rec_rid[b+3]);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_head = 1'b0; bus.in_tail = 1'b0; bus.hop_ready = 1'b0;
    test_reset();
    test_clean();
    test_long_path();
    test_backpressure();
    test_bad_header();
    test_missing_body();
    test_reset_mid_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/trace_eject.md
Name: trace_eject

Overview:
- Destination-side ejection unit on the router's local port (port 4). It consumes packets whose header was source-routed and then stamped hop by hop on the way through the hypercube.
- Per packet it captures the header and first body flit, unpacks the recorded router-ID trace, and checks hop count against the header's num/idx fields.
- It streams one hop record per cycle to the local core or a debug monitor, then reports packet done/error.

Parameters:
- ROUTERID, 0, ID of the owning router (4 bits used); final trace entry must equal it.
- MAX_HOPS, 16, hop slots in the path field; num above this is an error.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- in_valid  in  1  flit present on local output port
- in_ready  out  1  block can accept flit this cycle
- in_data  in  `DATA_WIDTH  flit; num at [`NUM_MSB:`NUM_LSB], idx at [`IDX_MSB:`IDX_LSB], path at [`DATA_MSB -: 32]
- in_head  in  1  flit is header
- in_tail  in  1  flit is last of packet (may coincide with in_head)
- hop_valid  out  1  hop record valid
- hop_ready  in  1  consumer accepts hop record
- hop_idx  out  5  hop number, 1..num
- hop_rid  out  4  router ID recorded at that hop
- hop_last  out  1  final hop of packet
- hop_port  out  2  path-field port taken at that hop (only with TRACE_PORT_EN)
- pkt_done  out  1  one-cycle pulse: packet fully processed
- pkt_err  out  1  one-cycle pulse with pkt_done: packet failed a check
- err_code  out  2  00 ok, 01 bad num, 10 idx!=num, 11 missing body / rid mismatch; valid with pkt_done

Behaviour:
- Reset (async): state=IDLE; in_ready=0, hop_valid=0, pkt_done=0, pkt_err=0, err_code=0, hop_idx=0, hop_rid=0, hop_last=0.
- FSM states: IDLE, BODY, DRAIN, EMIT, DONE.
- in_ready=1 in IDLE, BODY and DRAIN; 0 in EMIT and DONE.
- A flit transfers when in_valid&&in_ready.

IDLE:
- Accepts only head flits. A non-head flit is consumed and dropped, with no pulse.
- On head, latch num, idx, 32-bit path, and rid slots 13..16 from in_data[(k-13)*4 +: 4].
- If num==0 or num>MAX_HOPS: err=01. Else if idx!=num: err=10.
- Head with in_tail and num>12 → err=11, go DONE. Head with in_tail and num<=12 → err=11, go DONE (slots 1..12 live in body).
- Head without tail → BODY.

BODY:
- Next flit supplies slots 1..12 from in_data[(k-1)*4 +: 4].
- If this flit is a head: abort the current packet with err=11, DONE for one cycle, then IDLE. The new head is not consumed that cycle; in_ready drops.
- Tail → EMIT if no error so far, else DONE. Non-tail → DRAIN.

DRAIN:
- Consume flits until tail, then EMIT or DONE.
- A head in DRAIN is handled as in BODY.

EMIT:
- hop_idx counts 1..num. Advance only when hop_valid&&hop_ready; hop_valid stays high with stable data while stalled.
- hop_rid is the slot at hop_idx; hop_last=(hop_idx==num).
- After the last handshake, go DONE.
- Check: if slot[num]!=ROUTERID, set err=11. The records are still emitted.

DONE:
- Single cycle: pkt_done=1; pkt_err=(err!=0); err_code=err. Then IDLE.
- Header-to-first-hop_valid latency: 1 cycle after the tail is accepted.

Other rules:
- Reset asserted mid-packet aborts immediately; no pulse afterwards.
- All index arithmetic is 5-bit unsigned. Slot index 0 is never read.

Optional Feature:
- Macro: TRACE_PORT_EN.
- Defined: hop_port present; equals path[31-2*(hop_idx-1) -: 2] of the latched path, stable with hop_rid.
- Undefined: hop_port port and path latch are removed, and the path bits of the header are ignored.

Decomposition:
- Shared package/defines.v gets: FSM state encodings, err_code constants (TE_OK, TE_BADNUM, TE_IDX, TE_TRACE), RID_WIDTH=4, slot bases 13 and 1.
- Existing `NUM_*, `IDX_*, `DATA_* macros are reused unchanged.
- One sub-module, trace_slot_mux: combinational select of 4-bit rid (and 2-bit port) from latched header/body fields by hop index.

Test Plan:
- Clean 4-hop packet: head num=4, idx=4, body slots 1..4={3,1,5,ROUTERID}, tail on body, hop_ready=1 → 4 hop records (idx 1..4, rids 3,1,5,ROUTERID), hop_last on 4th, then pkt_done=1, pkt_err=0.
- Long 14-hop path: num=14, idx=14, header slots 13,14={9,ROUTERID}, body slots 1..12 filled → 14 records in order, correct slot crossover 12→13.
- Backpressure: hop_ready toggled 1,0,0,1 during EMIT → hop_idx/hop_rid held while stalled, no records lost or duplicated, in_ready=0 throughout EMIT.
- Bad header: num=0 → no hop records, pkt_done with err_code=01. idx=3 with num=5 → err_code=10.
- Missing body: head+tail same flit, num=2 → pkt_err, err_code=11, zero records. New head arriving in BODY → err_code=11, and the next packet then processes normally.
- Async reset asserted mid-EMIT → all outputs 0 within the same cycle, state IDLE, next packet clean. With TRACE_PORT_EN, hop_port matches path bits for each hop.
